// File: rtl/bf_pkg.sv
// Shared Brainfuck definitions: opcodes, source characters,
// loader states and loader error codes.
package bf_pkg;

  typedef enum logic [2:0] {
    OP_INC   = 3'd0,
    OP_DEC   = 3'd1,
    OP_RIGHT = 3'd2,
    OP_LEFT  = 3'd3,
    OP_JZ    = 3'd4,
    OP_JNZ   = 3'd5,
    OP_OUT   = 3'd6,
    OP_IN    = 3'd7
  } opcode_e;

  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_GT    = 8'h3E;
  localparam logic [7:0] CH_LT    = 8'h3C;
  localparam logic [7:0] CH_LBR   = 8'h5B;
  localparam logic [7:0] CH_RBR   = 8'h5D;
  localparam logic [7:0] CH_DOT   = 8'h2E;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE,
    S_ERROR
  } ld_state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNMATCHED = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_UNCLOSED  = 2'd3;

  typedef struct packed {
    logic    legal;
    opcode_e op;
  } enc_t;

endpackage

// File: rtl/bf_program_loader_if.sv
// Character stream handshake between a program source
// and the loader.
interface bf_program_loader_if;
  logic       char_valid_in;
  logic [7:0] char_in;
  logic       char_last_in;
  logic       char_ready_out;

  modport master (
    output char_valid_in,
    output char_in,
    output char_last_in,
    input  char_ready_out
  );

  modport slave (
    input  char_valid_in,
    input  char_in,
    input  char_last_in,
    output char_ready_out
  );
endinterface

// File: rtl/bf_opcode_encoder.sv
// Combinational ASCII to opcode map; any other byte
// is a comment and comes out with legal=0.
module bf_opcode_encoder
  import bf_pkg::*;
(
  input  logic [7:0] i_char,
  output enc_t       o_enc
);

  always_comb begin
    o_enc.legal = 1'b1;
    o_enc.op    = OP_INC;
    unique case (1'b1)
      (i_char == CH_PLUS):  o_enc.op = OP_INC;
      (i_char == CH_MINUS): o_enc.op = OP_DEC;
      (i_char == CH_GT):    o_enc.op = OP_RIGHT;
      (i_char == CH_LT):    o_enc.op = OP_LEFT;
      (i_char == CH_LBR):   o_enc.op = OP_JZ;
      (i_char == CH_RBR):   o_enc.op = OP_JNZ;
      (i_char == CH_DOT):   o_enc.op = OP_OUT;
      (i_char == CH_COMMA): o_enc.op = OP_IN;
      default:              o_enc.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// Streams ASCII Brainfuck source into instruction memory,
// tracking bracket balance and program length.
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int WIDTH_ADDR = 16,
  parameter int MAX_LEN    = 65535
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  bf_program_loader_if.slave    s_if,
  output logic                  mem_write_out,
  output logic [WIDTH_ADDR-1:0] mem_addr_out,
  output logic [2:0]            mem_data_out,
  output logic [WIDTH_ADDR-1:0] prog_len_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [1:0]            err_code_out
);

  localparam logic [WIDTH_ADDR-1:0] LP_MAX =
    WIDTH_ADDR'(MAX_LEN);

  ld_state_e             r_state, w_state_nx;
  logic [WIDTH_ADDR-1:0] r_count, w_count_nx;
  logic [WIDTH_ADDR-1:0] r_depth, w_depth_nx;
  logic [1:0]            r_err, w_err_nx;
  logic                  r_wr, w_wr_nx;
  logic [WIDTH_ADDR-1:0] r_addr, w_addr_nx;
  logic [2:0]            r_data, w_data_nx;
  logic                  w_accept;
  enc_t                  w_enc;

  bf_opcode_encoder u_enc (
    .i_char (s_if.char_in),
    .o_enc  (w_enc)
  );

  assign w_accept = s_if.char_valid_in
                  && (r_state == S_LOAD);

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_depth_nx = r_depth;
    w_err_nx   = r_err;
    w_wr_nx    = 1'b0;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    unique case (r_state)
      S_LOAD: begin
        if (w_accept) begin
          // Errors win over the end-of-program check.
          if (w_enc.legal && w_enc.op == OP_JNZ
              && r_depth == '0) begin
            w_state_nx = S_ERROR;
            w_err_nx   = ERR_UNMATCHED;
          end else if (w_enc.legal
                       && r_count == LP_MAX) begin
            w_state_nx = S_ERROR;
            w_err_nx   = ERR_OVERFLOW;
          end else begin
            if (w_enc.legal) begin
              w_wr_nx    = 1'b1;
              w_addr_nx  = r_count;
              w_data_nx  = w_enc.op;
              w_count_nx = r_count + 1'b1;
              if (w_enc.op == OP_JZ)
                w_depth_nx = r_depth + 1'b1;
              else if (w_enc.op == OP_JNZ)
                w_depth_nx = r_depth - 1'b1;
            end
            if (s_if.char_last_in) begin
              if (w_depth_nx == '0) begin
                w_state_nx = S_DONE;
              end else begin
                w_state_nx = S_ERROR;
                w_err_nx   = ERR_UNCLOSED;
              end
            end
          end
        end
      end
      default: begin
        if (start_in) begin
          w_state_nx = S_LOAD;
          w_count_nx = '0;
          w_depth_nx = '0;
          w_err_nx   = ERR_NONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_depth <= '0;
      r_err   <= ERR_NONE;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      r_depth <= w_depth_nx;
      r_err   <= w_err_nx;
      r_wr    <= w_wr_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
    end
  end

  assign s_if.char_ready_out = (r_state == S_LOAD);
  assign mem_write_out = r_wr;
  assign mem_addr_out  = r_addr;
  assign mem_data_out  = r_data;
  assign prog_len_out  = r_count;
  assign busy_out      = (r_state == S_LOAD);
  assign done_out      = (r_state == S_DONE);
  assign error_out     = (r_state == S_ERROR);
  assign err_code_out  = r_err;

endmodule
